// File: rtl/time_set_ctrl.sv
// Set-time controller for the hh:mm:ss timekeeper: two debounced buttons step
// through hour/minute editing, commit with a one-cycle load, and drive a blink mask.

module time_set_btn #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_n,
  output logic o_event
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RP_W = $clog2(RP_MAX + 1);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE - 1);

  logic [1:0]      r_sync;
  logic            r_level;      // debounced level, 1 = pressed
  logic [DB_W-1:0] r_db_cnt;
  logic [RP_W-1:0] r_rep_cnt;
  logic            r_rep_armed;  // first (long) repeat delay has elapsed
  logic            r_event;

  logic w_sample;
  logic w_flip;
  logic w_level_next;
  logic w_press;
  logic w_repeat;

  assign w_sample     = ~r_sync[1];
  assign w_flip       = (w_sample != r_level) && (r_db_cnt == DB_LAST);
  assign w_level_next = w_flip ? w_sample : r_level;
  assign w_press      = w_flip && w_sample;
  // Repeats look at the next level so a debounced release suppresses one on the same edge.
  assign w_repeat     = REPEAT_EN && w_level_next && !w_press &&
                        (r_rep_cnt == (r_rep_armed ? RATE_LAST : DELAY_LAST));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync      <= 2'b11;
      r_level     <= 1'b0;
      r_db_cnt    <= '0;
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
      r_event     <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn_n};
      r_level <= w_level_next;

      if ((w_sample == r_level) || w_flip) r_db_cnt <= '0;
      else                                 r_db_cnt <= r_db_cnt + DB_W'(1);

      if (!w_level_next || w_press || w_repeat) r_rep_cnt <= '0;
      else                                      r_rep_cnt <= r_rep_cnt + RP_W'(1);

      if (!w_level_next || w_press) r_rep_armed <= 1'b0;
      else if (w_repeat)            r_rep_armed <= 1'b1;

      r_event <= w_press || w_repeat;
    end
  end

  assign o_event = r_event;

endmodule

module time_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter int BLINK_HALF      = 12500000,
  parameter int IDLE_TIMEOUT    = 500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode_n,
  input  logic       btn_inc_n,
  input  logic [5:0] hours_in,
  input  logic [5:0] minutes_in,
  output logic       run_en,
  output logic       load,
  output logic [5:0] hours_out,
  output logic [5:0] minutes_out,
  output logic [5:0] disp_hours,
  output logic [5:0] disp_minutes,
  output logic [5:0] blank_mask
);

  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam int BL_W   = $clog2(BLINK_HALF + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [BL_W-1:0]   BL_LAST   = BL_W'(BLINK_HALF - 1);
  localparam logic [5:0] BLANK_HOURS   = 6'b110000;
  localparam logic [5:0] BLANK_MINUTES = 6'b001100;

  typedef enum logic [1:0] {S_RUN, S_SET_H, S_SET_M, S_COMMIT} state_t;

  state_t            r_state;
  logic [5:0]        r_sh_h;
  logic [5:0]        r_sh_m;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [BL_W-1:0]   r_blink_cnt;
  logic              r_blink_phase;  // 1 = blank half-period
  logic              r_run_en;
  logic              r_load;
  logic [5:0]        r_hours_out;
  logic [5:0]        r_minutes_out;
  logic [5:0]        r_disp_h;
  logic [5:0]        r_disp_m;
  logic [5:0]        r_blank;

  logic              w_mode_ev;
  logic              w_inc_ev;
  state_t            w_state_next;
  logic [5:0]        w_sh_h_next;
  logic [5:0]        w_sh_m_next;
  logic [IDLE_W-1:0] w_idle_next;
  logic              w_restart;
  logic [BL_W-1:0]   w_blink_cnt_next;
  logic              w_blink_phase_next;
  logic              w_editing_next;
  logic [5:0]        w_blank_next;

  time_set_btn #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_EN      (1'b0),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE)
  ) u_btn_mode (
    .clk    (clk),
    .rst    (rst),
    .i_btn_n(btn_mode_n),
    .o_event(w_mode_ev)
  );

  time_set_btn #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_EN      (1'b1),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE)
  ) u_btn_inc (
    .clk    (clk),
    .rst    (rst),
    .i_btn_n(btn_inc_n),
    .o_event(w_inc_ev)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_sh_h_next  = r_sh_h;
    w_sh_m_next  = r_sh_m;
    w_idle_next  = r_idle_cnt;
    w_restart    = 1'b0;
    unique case (r_state)
      S_RUN: begin
        w_idle_next = '0;
        if (w_mode_ev) begin
          w_state_next = S_SET_H;
          w_sh_h_next  = (hours_in > 6'd23)   ? 6'd0 : hours_in;
          w_sh_m_next  = (minutes_in > 6'd59) ? 6'd0 : minutes_in;
          w_restart    = 1'b1;
        end
      end
      S_SET_H, S_SET_M: begin
        // Mode wins over a coincident inc event.
        if (w_mode_ev) begin
          w_state_next = (r_state == S_SET_H) ? S_SET_M : S_COMMIT;
          w_idle_next  = '0;
          w_restart    = 1'b1;
        end else if (w_inc_ev) begin
          w_idle_next = '0;
          w_restart   = 1'b1;
          if (r_state == S_SET_H) w_sh_h_next = (r_sh_h == 6'd23) ? 6'd0 : r_sh_h + 6'd1;
          else                    w_sh_m_next = (r_sh_m == 6'd59) ? 6'd0 : r_sh_m + 6'd1;
        end else if (r_idle_cnt == IDLE_LAST) begin
          w_state_next = S_RUN;
          w_idle_next  = '0;
        end else begin
          w_idle_next = r_idle_cnt + IDLE_W'(1);
        end
      end
      default: w_state_next = S_RUN;
    endcase
  end

  always_comb begin
    w_blink_cnt_next   = r_blink_cnt + BL_W'(1);
    w_blink_phase_next = r_blink_phase;
    if (w_restart || !((r_state == S_SET_H) || (r_state == S_SET_M))) begin
      w_blink_cnt_next   = '0;
      w_blink_phase_next = 1'b0;
    end else if (r_blink_cnt == BL_LAST) begin
      w_blink_cnt_next   = '0;
      w_blink_phase_next = ~r_blink_phase;
    end
  end

  always_comb begin
    w_editing_next = (w_state_next == S_SET_H) || (w_state_next == S_SET_M);
    w_blank_next   = 6'd0;
    if (w_blink_phase_next) begin
      if (w_state_next == S_SET_H)      w_blank_next = BLANK_HOURS;
      else if (w_state_next == S_SET_M) w_blank_next = BLANK_MINUTES;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_RUN;
      r_sh_h        <= 6'd0;
      r_sh_m        <= 6'd0;
      r_idle_cnt    <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_run_en      <= 1'b1;
      r_load        <= 1'b0;
      r_hours_out   <= 6'd0;
      r_minutes_out <= 6'd0;
      r_disp_h      <= 6'd0;
      r_disp_m      <= 6'd0;
      r_blank       <= 6'd0;
    end else begin
      r_state       <= w_state_next;
      r_sh_h        <= w_sh_h_next;
      r_sh_m        <= w_sh_m_next;
      r_idle_cnt    <= w_idle_next;
      r_blink_cnt   <= w_blink_cnt_next;
      r_blink_phase <= w_blink_phase_next;
      r_run_en      <= (w_state_next == S_RUN);
      r_load        <= (w_state_next == S_COMMIT);
      if (w_state_next == S_COMMIT) begin
        r_hours_out   <= r_sh_h;
        r_minutes_out <= r_sh_m;
      end
      r_disp_h <= w_editing_next ? w_sh_h_next : hours_in;
      r_disp_m <= w_editing_next ? w_sh_m_next : minutes_in;
      r_blank  <= w_blank_next;
    end
  end

  assign run_en       = r_run_en;
  assign load         = r_load;
  assign hours_out    = r_hours_out;
  assign minutes_out  = r_minutes_out;
  assign disp_hours   = r_disp_h;
  assign disp_minutes = r_disp_m;
  assign blank_mask   = r_blank;

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Button-driven controller that sequences the hh:mm:ss timekeeper. It gates timekeeper counting and lets the user edit hours and then minutes with two pushbuttons. It commits the edited time back with a one-cycle load pulse. It sits between the timekeeper and the 6-digit display multiplexer, supplying the displayed hours/minutes and a per-digit blink mask.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable samples before a button level is accepted (20 ms @ 50 MHz)
REPEAT_DELAY, 25000000, cycles inc must be held after the press before auto-repeat starts
REPEAT_RATE, 5000000, cycles between auto-repeat increments
BLINK_HALF, 12500000, cycles per blink half-period
IDLE_TIMEOUT, 500000000, cycles without a press event in a set state before the edit is abandoned

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
btn_mode_n  in  1  raw mode pushbutton, asynchronous, active-low
btn_inc_n  in  1  raw increment pushbutton, asynchronous, active-low
hours_in  in  6  current hours from timekeeper, 0..23
minutes_in  in  6  current minutes from timekeeper, 0..59
run_en  out  1  timekeeper count enable
load  out  1  one-cycle pulse: timekeeper loads hours_out/minutes_out and clears seconds/prescaler
hours_out  out  6  committed hours, valid when load=1
minutes_out  out  6  committed minutes, valid when load=1
disp_hours  out  6  hours to display
disp_minutes  out  6  minutes to display
blank_mask  out  6  1 = blank digit; bit0 sec units, bit1 sec tens, bit2 min units, bit3 min tens, bit4 hour units, bit5 hour tens

Behaviour:
- Reset (async, rst=1):
  - state RUN; run_en=1; load=0; blank_mask=0.
  - hours_out, minutes_out and the shadow registers sh_h, sh_m are 0.
  - Debounced levels are released; all counters are 0.
  - Reset mid-edit discards the edit and produces no load.
- Input conditioning:
  - Each button passes through a 2-flop synchronizer.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive samples that differ from it.
  - A press event is a 1-cycle pulse on a debounced released->pressed transition. Release generates no event.
  - Input-to-event latency is 2 + DEBOUNCE_CYCLES cycles.
- Auto-repeat:
  - While debounced inc stays pressed, an extra inc event fires REPEAT_DELAY cycles after the press event, then every REPEAT_RATE cycles.
  - Release stops repeats immediately.
- FSM states: RUN, SET_H, SET_M, COMMIT.
  - RUN + mode event -> SET_H. Capture sh_h=hours_in and sh_m=minutes_in; an out-of-range value (h>23, m>59) is captured as 0. run_en=0 from the next cycle.
  - SET_H + mode event -> SET_M.
  - SET_M + mode event -> COMMIT.
  - COMMIT lasts exactly 1 cycle: load=1, hours_out=sh_h, minutes_out=sh_m. Next state RUN with run_en=1.
  - SET_H/SET_M + IDLE_TIMEOUT cycles with no mode or inc event (repeats count as events) -> RUN, no load, run_en=1.
  - The idle counter clears on every event and on entering SET_H.
- Increment:
  - SET_H: sh_h = (sh_h==23) ? 0 : sh_h+1.
  - SET_M: sh_m = (sh_m==59) ? 0 : sh_m+1.
  - Inc events in RUN and COMMIT are ignored.
- Simultaneous events: mode and inc in the same cycle -> mode is acted on, inc is dropped.
- Display:
  - disp_hours/disp_minutes = sh_h/sh_m in SET_H and SET_M; otherwise = hours_in/minutes_in (registered, 1-cycle latency).
  - The blink phase toggles every BLINK_HALF cycles.
  - The phase counter resets to 0 (visible phase) on entry to SET_H, on entry to SET_M and on every accepted increment.
  - blank_mask = 6'b110000 in SET_H during the blank phase; 6'b001100 in SET_M during the blank phase; 0 otherwise.
- All outputs are registered. load is never asserted for more than 1 cycle and never outside COMMIT.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5, BLINK_HALF=8, IDLE_TIMEOUT=200.
1. Reset, then idle 100 cycles with hours_in=12, minutes_in=34 -> run_en=1, load never asserted, blank_mask=0, disp shows 12:34.
2. Bounce btn_mode_n (toggle every 2 cycles for 10 cycles), then hold low 10 cycles -> exactly one mode event; state SET_H, run_en=0, sh_h=12, sh_m=34.
3. In SET_H with sh_h=22, press inc 3 times -> disp_hours 23, 0, 1. Mode, then in SET_M with sh_m=58 press inc twice -> 59, 0. Mode -> a single load pulse with hours_out=1, minutes_out=0, then run_en=1.
4. In SET_M hold inc 60 cycles after its press event -> 1 + 1 + floor((60-20)/5) = 10 increments in total, wrapping mod 60. blank_mask bits[3:2]=0 for 8 cycles after each increment.
5. Enter SET_H and apply no events for 200 cycles -> return to RUN, load=0, run_en=1, disp follows hours_in.
6. Assert rst while in SET_M with edits pending -> outputs at reset values immediately; no load; return to RUN.
7. Assert mode and inc events in the same cycle in SET_H -> state SET_M, sh_h unchanged.
